// File: rtl/cga_intr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cga_intr_pkg
// Purpose  : Shared types and constants for the CGA interrupt controller
//            vector generator status/sequencing stage.
// Contents : state_t - handshake sequencer states
//            VEC_W   - vector width (group bit + index)
//            IDX_W   - request index width
//            GRP_HI  - group-bit value that selects the high group
// Revision : 1.0 - initial release
// ============================================================================
package cga_intr_pkg;

    localparam int VEC_W = 4;
    localparam int IDX_W = 3;
    localparam logic GRP_HI = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        WREL = 2'd3
    } state_t;

endpackage : cga_intr_pkg
`default_nettype wire

// File: rtl/cga_intr_cntlr_vecgen_prienc.sv
`default_nettype none
// ============================================================================
// Module   : cga_intr_cntlr_vecgen_prienc
// Purpose  : Priority encoder with threshold compare for one request group.
//            A line is eligible when it is set and its index is at or above
//            the threshold; the highest eligible index wins.
// Ports    : i_req    [NREQ-1:0] request lines, active-high
//            i_thresh [IDX_W-1:0] minimum eligible index
//            o_valid             at least one eligible line
//            o_idx    [IDX_W-1:0] highest eligible index (0 when !o_valid)
// Revision : 1.0 - initial release
// ============================================================================
module cga_intr_cntlr_vecgen_prienc
    import cga_intr_pkg::*;
#(
    parameter int NREQ = 8
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_thresh,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    // Ascending scan: a later (higher) eligible index overwrites an earlier one.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i_req[i] && (i >= int'(i_thresh))) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule : cga_intr_cntlr_vecgen_prienc
`default_nettype wire

// File: rtl/cga_intr_cntlr_vecgen_stseq.sv
`default_nettype none
// ============================================================================
// Module   : cga_intr_cntlr_vecgen_stseq
// Purpose  : Threshold status registers and single-vector request/acknowledge
//            sequencer of the CGA interrupt controller vector generator.
// Ports    : sysclk      system clock (rising edge)
//            sys_rst_n   asynchronous active-low reset
//            HISIN_2_0   next high-group threshold from the ISMUX
//            LOSIN_2_0   next low-group threshold from the ISMUX
//            HIREQ_7_0   high-group pending requests
//            LOREQ_7_0   low-group pending requests
//            ACKN        CPU acknowledge, active-low, synchronous
//            HISTAT_2_0  high-group threshold register (to ISMUX)
//            LOSTAT_2_0  low-group threshold register (to ISMUX)
//            INTRQN      interrupt request, active-low
//            VEC_3_0     {group, index} of the request being presented
//            VECVLD      one-cycle strobe: vector consumed by the CPU
//            CLR_15_0    one-hot source clear, {high[7:0], low[7:0]}
// Revision : 1.0 - initial release
// ============================================================================
module cga_intr_cntlr_vecgen_stseq
    import cga_intr_pkg::*;
#(
    parameter int NREQ = 8
) (
    input  logic                 sysclk,
    input  logic                 sys_rst_n,
    input  logic [IDX_W-1:0]     HISIN_2_0,
    input  logic [IDX_W-1:0]     LOSIN_2_0,
    input  logic [NREQ-1:0]      HIREQ_7_0,
    input  logic [NREQ-1:0]      LOREQ_7_0,
    input  logic                 ACKN,
    output logic [IDX_W-1:0]     HISTAT_2_0,
    output logic [IDX_W-1:0]     LOSTAT_2_0,
    output logic                 INTRQN,
    output logic [VEC_W-1:0]     VEC_3_0,
    output logic                 VECVLD,
    output logic [2*NREQ-1:0]    CLR_15_0
);

    logic [IDX_W-1:0]  r_hiStat;
    logic [IDX_W-1:0]  r_loStat;
    state_t            r_state;
    state_t            w_nextState;
    logic              r_intrqn;
    logic              w_nextIntrqn;
    logic [VEC_W-1:0]  r_vec;
    logic [VEC_W-1:0]  w_nextVec;
    logic              r_vecVld;
    logic              w_nextVecVld;
    logic [2*NREQ-1:0] r_clr;
    logic [2*NREQ-1:0] w_nextClr;

    logic              w_hiValid;
    logic [IDX_W-1:0]  w_hiIdx;
    logic              w_loValid;
    logic [IDX_W-1:0]  w_loIdx;
    logic              w_candValid;
    logic [VEC_W-1:0]  w_candVec;
    logic              w_srcLive;

    // Thresholds load every edge; holding is done by ISMUX recirculation.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hiStat <= '0;
            r_loStat <= '0;
        end else begin
            r_hiStat <= HISIN_2_0;
            r_loStat <= LOSIN_2_0;
        end
    end

    cga_intr_cntlr_vecgen_prienc #(.NREQ(NREQ)) u_hiEnc (
        .i_req    (HIREQ_7_0),
        .i_thresh (r_hiStat),
        .o_valid  (w_hiValid),
        .o_idx    (w_hiIdx)
    );

    cga_intr_cntlr_vecgen_prienc #(.NREQ(NREQ)) u_loEnc (
        .i_req    (LOREQ_7_0),
        .i_thresh (r_loStat),
        .o_valid  (w_loValid),
        .o_idx    (w_loIdx)
    );

    // High group always has precedence over the low group.
    assign w_candValid = w_hiValid | w_loValid;
    assign w_candVec   = w_hiValid ? {GRP_HI, w_hiIdx} : {~GRP_HI, w_loIdx};

    // Level of the source that the latched vector points at; used to detect
    // a request withdrawn before the CPU acknowledged it.
    assign w_srcLive = (r_vec[VEC_W-1] == GRP_HI) ? HIREQ_7_0[r_vec[IDX_W-1:0]]
                                                  : LOREQ_7_0[r_vec[IDX_W-1:0]];

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= IDLE;
            r_intrqn <= 1'b1;
            r_vec    <= '0;
            r_vecVld <= 1'b0;
            r_clr    <= '0;
        end else begin
            r_state  <= w_nextState;
            r_intrqn <= w_nextIntrqn;
            r_vec    <= w_nextVec;
            r_vecVld <= w_nextVecVld;
            r_clr    <= w_nextClr;
        end
    end

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so that every port is driven straight from a flop.
    always_comb begin
        w_nextState  = r_state;
        w_nextIntrqn = 1'b1;
        w_nextVec    = r_vec;
        w_nextVecVld = 1'b0;
        w_nextClr    = '0;

        case (r_state)
            IDLE: begin
                if (w_candValid) begin
                    w_nextVec    = w_candVec;
                    w_nextIntrqn = 1'b0;
                    w_nextState  = REQ;
                end
            end
            REQ: begin
                // Acknowledge takes precedence over a simultaneous withdrawal.
                if (!ACKN) begin
                    w_nextVecVld   = 1'b1;
                    w_nextClr[r_vec] = 1'b1;
                    w_nextState    = ACK;
                end else if (!w_srcLive) begin
                    w_nextState = IDLE;
                end else begin
                    w_nextIntrqn = 1'b0;
                end
            end
            ACK: begin
                w_nextState = WREL;
            end
            WREL: begin
                if (ACKN) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign HISTAT_2_0 = r_hiStat;
    assign LOSTAT_2_0 = r_loStat;
    assign INTRQN     = r_intrqn;
    assign VEC_3_0    = r_vec;
    assign VECVLD     = r_vecVld;
    assign CLR_15_0   = r_clr;

endmodule : cga_intr_cntlr_vecgen_stseq
`default_nettype wire

// File: tb/tb_cga_intr_cntlr_vecgen_stseq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cga_intr_cntlr_vecgen_stseq
// Purpose  : Self-checking bench for cga_intr_cntlr_vecgen_stseq. Expected
//            acknowledge transactions are queued by the stimulus process and
//            matched by a monitor on each VECVLD strobe; register state is
//            checked against hand-computed values between edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cga_intr_cntlr_vecgen_stseq;

    typedef struct packed {
        logic [3:0]  vec;
        logic [15:0] clr;
    } exp_t;

    logic        sysclk;
    logic        sys_rst_n;
    logic [2:0]  HISIN_2_0;
    logic [2:0]  LOSIN_2_0;
    logic [7:0]  HIREQ_7_0;
    logic [7:0]  LOREQ_7_0;
    logic        ACKN;
    logic [2:0]  HISTAT_2_0;
    logic [2:0]  LOSTAT_2_0;
    logic        INTRQN;
    logic [3:0]  VEC_3_0;
    logic        VECVLD;
    logic [15:0] CLR_15_0;

    int   nVec = 0;
    int   nErr = 0;
    exp_t sbQ[$];

    cga_intr_cntlr_vecgen_stseq #(.NREQ(8)) dut (
        .sysclk     (sysclk),
        .sys_rst_n  (sys_rst_n),
        .HISIN_2_0  (HISIN_2_0),
        .LOSIN_2_0  (LOSIN_2_0),
        .HIREQ_7_0  (HIREQ_7_0),
        .LOREQ_7_0  (LOREQ_7_0),
        .ACKN       (ACKN),
        .HISTAT_2_0 (HISTAT_2_0),
        .LOSTAT_2_0 (LOSTAT_2_0),
        .INTRQN     (INTRQN),
        .VEC_3_0    (VEC_3_0),
        .VECVLD     (VECVLD),
        .CLR_15_0   (CLR_15_0)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic tick;
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every VECVLD strobe must match the oldest queued expectation.
    always @(negedge sysclk) begin
        exp_t e;
        if (sys_rst_n && VECVLD) begin
            nVec++;
            if (sbQ.size() == 0) begin
                nErr++;
                $display("FAIL unexpected_vecvld: got vec 0x%0h clr 0x%0h, expected no strobe",
                         VEC_3_0, CLR_15_0);
            end else begin
                e = sbQ.pop_front();
                if (VEC_3_0 !== e.vec || CLR_15_0 !== e.clr) begin
                    nErr++;
                    $display("FAIL ack_xfer: got vec 0x%0h clr 0x%0h, expected vec 0x%0h clr 0x%0h",
                             VEC_3_0, CLR_15_0, e.vec, e.clr);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        sys_rst_n = 1'b0;
        HISIN_2_0 = 3'd0;
        LOSIN_2_0 = 3'd0;
        HIREQ_7_0 = 8'h00;
        LOREQ_7_0 = 8'h00;
        ACKN      = 1'b1;
        repeat (2) tick();

        // Reset state
        chk("rst_histat", 32'(HISTAT_2_0), 32'd0);
        chk("rst_intrqn", 32'(INTRQN), 32'd1);
        chk("rst_vec", 32'(VEC_3_0), 32'h0);
        chk("rst_vecvld", 32'(VECVLD), 32'd0);
        chk("rst_clr", 32'(CLR_15_0), 32'h0);

        // Threshold load
        sys_rst_n = 1'b1;
        HISIN_2_0 = 3'd5;
        LOSIN_2_0 = 3'd2;
        tick();
        chk("stat_hi", 32'(HISTAT_2_0), 32'd5);
        chk("stat_lo", 32'(LOSTAT_2_0), 32'd2);
        chk("stat_intrqn", 32'(INTRQN), 32'd1);
        chk("stat_vecvld", 32'(VECVLD), 32'd0);

        // High group wins; bit 2 below threshold 5, bit 5 selected
        HIREQ_7_0 = 8'h24;
        LOREQ_7_0 = 8'h80;
        tick();
        chk("hi_req_intrqn", 32'(INTRQN), 32'd0);
        chk("hi_req_vec", 32'(VEC_3_0), 32'hD);
        sbQ.push_back('{vec: 4'hD, clr: 16'h2000});
        ACKN = 1'b0;
        tick();
        chk("hi_ack_intrqn", 32'(INTRQN), 32'd1);
        chk("hi_ack_vecvld", 32'(VECVLD), 32'd1);
        ACKN      = 1'b1;
        HIREQ_7_0 = 8'h00;
        LOREQ_7_0 = 8'h00;
        tick();
        chk("hi_wrel_vecvld", 32'(VECVLD), 32'd0);
        chk("hi_wrel_clr", 32'(CLR_15_0), 32'h0);
        tick();

        // Low group selected when high request sits below threshold
        HISIN_2_0 = 3'd7;
        LOSIN_2_0 = 3'd3;
        tick();
        chk("stat2_hi", 32'(HISTAT_2_0), 32'd7);
        chk("stat2_lo", 32'(LOSTAT_2_0), 32'd3);
        HIREQ_7_0 = 8'h40;
        LOREQ_7_0 = 8'h0A;
        tick();
        chk("lo_req_intrqn", 32'(INTRQN), 32'd0);
        chk("lo_req_vec", 32'(VEC_3_0), 32'h3);

        // Withdrawal: source bit drops while ACKN high
        LOREQ_7_0 = 8'h02;
        tick();
        chk("wd_intrqn", 32'(INTRQN), 32'd1);
        chk("wd_vecvld", 32'(VECVLD), 32'd0);
        tick();
        chk("wd_idle_intrqn", 32'(INTRQN), 32'd1);

        // ACK beats a simultaneous withdrawal; ACKN held low for 4 cycles
        LOREQ_7_0 = 8'h0A;
        tick();
        chk("race_req_vec", 32'(VEC_3_0), 32'h3);
        chk("race_req_intrqn", 32'(INTRQN), 32'd0);
        sbQ.push_back('{vec: 4'h3, clr: 16'h0008});
        ACKN      = 1'b0;
        LOREQ_7_0 = 8'h02;
        tick();
        chk("race_ack_vecvld", 32'(VECVLD), 32'd1);
        chk("race_ack_intrqn", 32'(INTRQN), 32'd1);
        LOREQ_7_0 = 8'h0A;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wrel_hold_intrqn", 32'(INTRQN), 32'd1);
            chk("wrel_hold_vecvld", 32'(VECVLD), 32'd0);
        end
        ACKN      = 1'b1;
        LOREQ_7_0 = 8'h00;
        tick();
        chk("wrel_exit_intrqn", 32'(INTRQN), 32'd1);

        // Reset asserted while in ACK
        LOREQ_7_0 = 8'h0A;
        tick();
        chk("rst2_req_vec", 32'(VEC_3_0), 32'h3);
        ACKN = 1'b0;
        tick();
        sys_rst_n = 1'b0;
        #1;
        chk("rst2_vecvld", 32'(VECVLD), 32'd0);
        chk("rst2_clr", 32'(CLR_15_0), 32'h0);
        chk("rst2_intrqn", 32'(INTRQN), 32'd1);
        chk("rst2_vec", 32'(VEC_3_0), 32'h0);
        chk("rst2_histat", 32'(HISTAT_2_0), 32'd0);
        ACKN = 1'b1;
        tick();
        sys_rst_n = 1'b1;
        #1;
        chk("rst2_rel_intrqn", 32'(INTRQN), 32'd1);
        tick();
        // Arbitration used the reset thresholds (0), so high bit 6 wins
        chk("rearb_intrqn", 32'(INTRQN), 32'd0);
        chk("rearb_vec", 32'(VEC_3_0), 32'hE);
        chk("rearb_histat", 32'(HISTAT_2_0), 32'd7);
        sbQ.push_back('{vec: 4'hE, clr: 16'h4000});
        ACKN = 1'b0;
        tick();
        ACKN      = 1'b1;
        HIREQ_7_0 = 8'h00;
        LOREQ_7_0 = 8'h00;
        tick();
        tick();

        chk("sb_drained", 32'(sbQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule : tb_cga_intr_cntlr_vecgen_stseq
`default_nettype wire
